// File: rtl/writeback_unit_if.sv
// Execute/memory to register-file write port bundle for writeback_unit.
// The master side drives execute and memory inputs; the slave side is the writeback block.
interface writeback_unit_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = $clog2(DATAW)
);
    logic             ex_valid;
    logic             ex_ready;
    logic             ex_is_load;
    logic [2:0]       ex_funct3;
    logic [ADDRW-1:0] ex_rd;
    logic [DATAW-1:0] ex_result;
    logic             mem_rvalid;
    logic [DATAW-1:0] mem_rdata;
    logic             write_enable;
    logic [ADDRW-1:0] addr_rd;
    logic [DATAW-1:0] data_rd;
    logic             fwd_valid;
    logic [ADDRW-1:0] fwd_addr;
    logic [DATAW-1:0] fwd_data;
    logic             load_fault;

    modport master (
        output ex_valid, ex_is_load, ex_funct3, ex_rd, ex_result, mem_rvalid, mem_rdata,
        input  ex_ready, write_enable, addr_rd, data_rd, fwd_valid, fwd_addr, fwd_data,
               load_fault
    );

    modport slave (
        input  ex_valid, ex_is_load, ex_funct3, ex_rd, ex_result, mem_rvalid, mem_rdata,
        output ex_ready, write_enable, addr_rd, data_rd, fwd_valid, fwd_addr, fwd_data,
               load_fault
    );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write driver: ALU results and formatted RV32 loads, with a one-cycle
// forwarding copy of the last write and a fault pulse for bad or timed-out loads.
module writeback_unit #(
    parameter int DATAW   = 32,
    parameter int ADDRW   = $clog2(DATAW),
    parameter int TIMEOUT = 255
) (
    input logic             clock,
    input logic             reset,
    writeback_unit_if.slave bus
);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [ADDRW-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_off_q, ld_off_d;
    logic             write_enable_q, write_enable_d;
    logic [ADDRW-1:0] addr_rd_q, addr_rd_d;
    logic [DATAW-1:0] data_rd_q, data_rd_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [ADDRW-1:0] fwd_addr_q, fwd_addr_d;
    logic [DATAW-1:0] fwd_data_q, fwd_data_d;
    logic             load_fault_q, load_fault_d;

    logic             ld_bad;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [DATAW-1:0] ld_data;

    // Illegal funct3 or misaligned address, judged at accept time.
    always_comb begin
        ld_bad = 1'b0;
        case (bus.ex_funct3)
            3'b000, 3'b100: ld_bad = 1'b0;
            3'b001, 3'b101: ld_bad = bus.ex_result[0];
            3'b010:         ld_bad = |bus.ex_result[1:0];
            default:        ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = bus.mem_rdata[7:0];
        case (ld_off_q)
            2'd0: ld_byte = bus.mem_rdata[7:0];
            2'd1: ld_byte = bus.mem_rdata[15:8];
            2'd2: ld_byte = bus.mem_rdata[23:16];
            2'd3: ld_byte = bus.mem_rdata[31:24];
            default: ld_byte = bus.mem_rdata[7:0];
        endcase
        ld_half = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (ld_f3_q)
            3'b000:  ld_data = {{(DATAW-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(DATAW-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(DATAW-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(DATAW-16){1'b0}}, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ld_rd_d        = ld_rd_q;
        ld_f3_d        = ld_f3_q;
        ld_off_d       = ld_off_q;
        write_enable_d = 1'b0;
        addr_rd_d      = addr_rd_q;
        data_rd_d      = data_rd_q;
        load_fault_d   = 1'b0;
        fwd_valid_d    = write_enable_q;
        fwd_addr_d     = write_enable_q ? addr_rd_q : fwd_addr_q;
        fwd_data_d     = write_enable_q ? data_rd_q : fwd_data_q;

        case (state_q)
            IDLE: begin
                if (bus.ex_valid) begin
                    if (!bus.ex_is_load) begin
                        if (bus.ex_rd != '0) begin
                            write_enable_d = 1'b1;
                            addr_rd_d      = bus.ex_rd;
                            data_rd_d      = bus.ex_result;
                        end
                    end else if (ld_bad) begin
                        load_fault_d = 1'b1;
                    end else begin
                        ld_rd_d  = bus.ex_rd;
                        ld_f3_d  = bus.ex_funct3;
                        ld_off_d = bus.ex_result[1:0];
                        cnt_d    = '0;
                        state_d  = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                // A response arriving on the timeout cycle still completes the load.
                if (bus.mem_rvalid) begin
                    if (ld_rd_q != '0) begin
                        write_enable_d = 1'b1;
                        addr_rd_d      = ld_rd_q;
                        data_rd_d      = ld_data;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNTW'(TIMEOUT)) begin
                    load_fault_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ld_rd_q        <= '0;
            ld_f3_q        <= '0;
            ld_off_q       <= '0;
            write_enable_q <= 1'b0;
            addr_rd_q      <= '0;
            data_rd_q      <= '0;
            fwd_valid_q    <= 1'b0;
            fwd_addr_q     <= '0;
            fwd_data_q     <= '0;
            load_fault_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ld_rd_q        <= ld_rd_d;
            ld_f3_q        <= ld_f3_d;
            ld_off_q       <= ld_off_d;
            write_enable_q <= write_enable_d;
            addr_rd_q      <= addr_rd_d;
            data_rd_q      <= data_rd_d;
            fwd_valid_q    <= fwd_valid_d;
            fwd_addr_q     <= fwd_addr_d;
            fwd_data_q     <= fwd_data_d;
            load_fault_q   <= load_fault_d;
        end
    end

    assign bus.ex_ready     = (state_q == IDLE);
    assign bus.write_enable = write_enable_q;
    assign bus.addr_rd      = addr_rd_q;
    assign bus.data_rd      = data_rd_q;
    assign bus.fwd_valid    = fwd_valid_q;
    assign bus.fwd_addr     = fwd_addr_q;
    assign bus.fwd_data     = fwd_data_q;
    assign bus.load_fault   = load_fault_q;
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side driver for the core's register file: accepts completed ALU results and load responses, and formats load data (byte/half/word, signed/unsigned).
- Issues single-cycle writes on the register file's write port (write_enable/addr_rd/data_rd).
- The register file's read is registered, so a same-edge read returns the old value. This block therefore also exposes a one-cycle forwarding copy of the last write for the decode/execute bypass.
- Sits between execute/memory and the register file.

Parameters:
- DATAW, 32, datapath width; must be 32 (load formatting is RV32-specific).
- ADDRW, $clog2(DATAW), register index width (5).
- TIMEOUT, 255, maximum cycles in WAIT_MEM before a load is abandoned; must be >= 1.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ex_valid  in  1  execute presents a completed instruction.
- ex_ready  out  1  block can accept; high only in IDLE (combinational from state).
- ex_is_load  in  1  instruction is a load; result arrives later on mem_*.
- ex_funct3  in  3  load type; ignored when ex_is_load=0.
- ex_rd  in  ADDRW  destination register.
- ex_result  in  DATAW  ALU result (non-load), or effective address (load; only bits [1:0] used).
- mem_rvalid  in  1  load response valid, single-cycle pulse.
- mem_rdata  in  DATAW  aligned 32-bit word containing the load data.
- write_enable  out  1  register-file write strobe.
- addr_rd  out  ADDRW  register-file write index.
- data_rd  out  DATAW  register-file write data.
- fwd_valid  out  1  a write landed on the previous edge.
- fwd_addr  out  ADDRW  index of that write.
- fwd_data  out  DATAW  data of that write.
- load_fault  out  1  single-cycle pulse on misaligned/illegal load or timeout.

Behaviour:
- Reset values: state=IDLE, timeout counter=0; write_enable, addr_rd, data_rd, fwd_valid, fwd_addr, fwd_data and load_fault are all 0. A reset during WAIT_MEM abandons the load with no write and no fault.
- All outputs except ex_ready are registered.
- States are IDLE and WAIT_MEM.
- IDLE, accept when ex_valid && ex_ready:
  - Non-load: on the next cycle, write_enable=1, addr_rd=ex_rd, data_rd=ex_result. Stay in IDLE. Back-to-back accepts give one write per cycle.
  - Load, legal and aligned: capture rd, funct3 and addr[1:0]; counter=0; go to WAIT_MEM.
  - Load, illegal funct3 (011, 110, 111) or misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]!=0): load_fault=1 on the next cycle, no write, stay in IDLE. The issuing stage does not send a memory request for such loads.
- IDLE, mem_rvalid: ignored, no write.
- WAIT_MEM:
  - ex_ready=0; the counter increments each cycle.
  - On mem_rvalid: write the formatted data on the next cycle, then return to IDLE.
  - On counter==TIMEOUT with no mem_rvalid: load_fault=1 on the next cycle, no write, return to IDLE.
  - mem_rvalid in the same cycle as counter==TIMEOUT: the response wins and no fault is raised.
- Load formatting, with b = mem_rdata byte at addr[1:0] and h = halfword at addr[1]:
  - 000 LB: sign-extend b.
  - 100 LBU: zero-extend b.
  - 001 LH: sign-extend h.
  - 101 LHU: zero-extend h.
  - 010 LW: full word.
- rd=0: the instruction completes normally (loads still wait for their response), but write_enable stays 0, addr_rd/data_rd are not updated, and fwd_valid stays 0.
- write_enable is high for exactly one cycle per write; addr_rd/data_rd hold their last values when write_enable=0.
- Forwarding: on each edge, fwd_valid<=write_enable, and fwd_addr/fwd_data<=addr_rd/data_rd when write_enable=1. The consumer compares fwd_addr against the rs index it read on the write edge and substitutes fwd_data.
- Latency:
  - ALU result: accept to write_enable is 1 cycle; the register file is updated on the following edge.
  - Load: mem_rvalid to write_enable is 1 cycle.

Test Plan:
- Reset, then non-load accepts of ex_rd=5 / 0xDEADBEEF and ex_rd=6 / 0x12345678 on consecutive cycles -> write_enable high on 2 consecutive cycles with those (addr_rd, data_rd); fwd_valid/fwd_addr/fwd_data follow one cycle later.
- mem_rdata=0x80F17F22 with each addr[1:0] -> LB addr 1 gives 0x0000007F; LB addr 3 gives 0xFFFFFF80; LBU addr 3 gives 0x00000080; LH addr 2 gives 0xFFFF80F1; LHU addr 0 gives 0x00007F22; LW addr 0 gives 0x80F17F22.
- Non-load and load with ex_rd=0 -> no write_enable and no fwd_valid; the load still consumes mem_rvalid and returns ex_ready=1 the cycle after the response.
- LW with addr 0x2 and funct3=011 -> load_fault pulse 1 cycle, no write, ex_ready stays 1; mem_rvalid in IDLE -> no write.
- With TIMEOUT=4, a load with no response -> load_fault 5 cycles after accept and IDLE; repeat with mem_rvalid at counter==4 -> write, no fault.
- Assert reset asynchronously mid-WAIT_MEM, then a late mem_rvalid -> all outputs 0 immediately, no write afterwards, ex_ready=1 after release.
